// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-request bus between three requesters and the writeback arbiter.
// Signals:
//   req      - bit i: requester i has a write pending
//   req_dest - requester i destination register in bits [3i+2:3i]
//   req_data - requester i write data in bits [DATA_W*(i+1)-1:DATA_W*i]
//   gnt      - one-hot grant back to the requesters
// Modports: master (requester side), slave (arbiter side).
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [2:0]          req;
    logic [8:0]          req_dest;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          gnt;

    modport master (output req, output req_dest, output req_data, input gnt);
    modport slave  (input req, input req_dest, input req_data, output gnt);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for 3 requesters with a pending-write scoreboard.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   bus                - requester interface (req/req_dest/req_data in, gnt out)
//   rsv_en_i/rsv_dest_i - reserve a destination register (mark it busy)
//   chk_addr_1_i/_2_i  - read addresses checked for hazards
//   hazard_1_o/_2_o    - checked register has a pending write
//   busy_o             - scoreboard bitmap (bit 0 always 0)
//   err_waw_o          - sticky: reservation made to an already busy register
//   reg_write_en_o/dest_o/data_o - registered register-file write port
module regfile_wb_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_arbiter_if.slave bus,
    input  logic              rsv_en_i,
    input  logic [2:0]        rsv_dest_i,
    input  logic [2:0]        chk_addr_1_i,
    input  logic [2:0]        chk_addr_2_i,
    output logic              hazard_1_o,
    output logic              hazard_2_o,
    output logic [7:0]        busy_o,
    output logic              err_waw_o,
    output logic              reg_write_en_o,
    output logic [2:0]        reg_write_dest_o,
    output logic [DATA_W-1:0] reg_write_data_o
);
    logic [1:0]        ptr_q, ptr_d, off, gi;
    logic [2:0]        rot, sum, g_dest, wdest_q, wdest_d;
    logic              any, rsv_hit, wen_q, wen_d, err_q, err_d;
    logic [DATA_W-1:0] g_data, wdata_q, wdata_d;
    logic [7:0]        busy_q, busy_d;

    always_comb begin
        // rot[k] = req[(ptr+k) mod 3], so priority search becomes a fixed scan from bit 0
        rot = ptr_q == 2'd1 ? {bus.req[0], bus.req[2:1]} :
              ptr_q == 2'd2 ? {bus.req[1:0], bus.req[2]} : bus.req;
        any = |rot;
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
        sum = {1'b0, (ptr_q == 2'd3 ? 2'd0 : ptr_q)} + {1'b0, off};
        gi = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
        bus.gnt = any ? 3'b001 << gi : 3'b000;
        g_dest = bus.req_dest[3*int'(gi) +: 3];
        g_data = bus.req_data[DATA_W*int'(gi) +: DATA_W];
        ptr_d = any ? (gi == 2'd2 ? 2'd0 : gi + 2'd1) : ptr_q;
        wen_d = any && g_dest != 3'd0;
        wdest_d = any ? g_dest : wdest_q;
        wdata_d = any ? g_data : wdata_q;
        rsv_hit = rsv_en_i && rsv_dest_i != 3'd0;
        // clear from the committing write first, then set, so a same-edge reservation wins
        busy_d = (busy_q & ~(wen_q ? 8'b1 << wdest_q : 8'h00)) | (rsv_hit ? 8'b1 << rsv_dest_i : 8'h00);
        busy_d[0] = 1'b0;
        err_d = err_q | (rsv_hit && busy_q[rsv_dest_i] && !(wen_q && wdest_q == rsv_dest_i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            wen_q   <= 1'b0;
            wdest_q <= 3'd0;
            wdata_q <= '0;
            busy_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            wdest_q <= wdest_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign hazard_1_o       = busy_q[chk_addr_1_i];
    assign hazard_2_o       = busy_q[chk_addr_2_i];
    assign busy_o           = busy_q;
    assign err_waw_o        = err_q;
    assign reg_write_en_o   = wen_q;
    assign reg_write_dest_o = wdest_q;
    assign reg_write_data_o = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench with a behavioural model checked every cycle plus literal expectations.
module tb_regfile_wb_arbiter;
    logic        clk, rst;
    logic        rsv_en;
    logic [2:0]  rsv_dest, chk1, chk2;
    logic        hz1, hz2, err, wen;
    logic [7:0]  busy;
    logic [2:0]  wdest;
    logic [15:0] wdata;
    int          checks = 0, errors = 0;

    regfile_wb_arbiter_if #(.DATA_W(16)) bus ();

    regfile_wb_arbiter #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rsv_en_i(rsv_en), .rsv_dest_i(rsv_dest),
        .chk_addr_1_i(chk1), .chk_addr_2_i(chk2),
        .hazard_1_o(hz1), .hazard_2_o(hz2), .busy_o(busy), .err_waw_o(err),
        .reg_write_en_o(wen), .reg_write_dest_o(wdest), .reg_write_data_o(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which requester wins, scanning from ptr with wraparound.
    function automatic int mgrant(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    int          m_ptr = 0;
    logic [7:0]  m_busy = 8'h00;
    logic        m_err = 1'b0, m_wen = 1'b0;
    logic [2:0]  m_dest = 3'd0;
    logic [15:0] m_data = 16'h0;

    always @(posedge clk or posedge rst) begin
        int g;
        logic [7:0] nb;
        if (rst) begin
            m_ptr <= 0; m_busy <= 8'h00; m_err <= 1'b0;
            m_wen <= 1'b0; m_dest <= 3'd0; m_data <= 16'h0;
        end else begin
            g = mgrant(bus.req, m_ptr);
            nb = m_busy;
            if (m_wen) nb[m_dest] = 1'b0;
            if (rsv_en && rsv_dest != 3'd0) begin
                if (m_busy[rsv_dest] && !(m_wen && m_dest == rsv_dest)) m_err <= 1'b1;
                nb[rsv_dest] = 1'b1;
            end
            m_busy <= nb;
            if (g >= 0) begin
                m_ptr  <= (g + 1) % 3;
                m_dest <= bus.req_dest[3*g +: 3];
                m_data <= bus.req_data[16*g +: 16];
                m_wen  <= bus.req_dest[3*g +: 3] != 3'd0;
            end else m_wen <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int g;
        g = mgrant(bus.req, m_ptr);
        chk("m_gnt", {29'd0, bus.gnt}, g < 0 ? 32'd0 : 32'd1 << g);
        chk("m_busy", {24'd0, busy}, {24'd0, m_busy});
        chk("m_hazard1", {31'd0, hz1}, {31'd0, m_busy[chk1]});
        chk("m_hazard2", {31'd0, hz2}, {31'd0, m_busy[chk2]});
        chk("m_err_waw", {31'd0, err}, {31'd0, m_err});
        chk("m_wen", {31'd0, wen}, {31'd0, m_wen});
        if (m_wen || rst) begin
            chk("m_wdest", {29'd0, wdest}, {29'd0, m_dest});
            chk("m_wdata", {16'd0, wdata}, {16'd0, m_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] d, input logic [15:0] v);
        bus.req[i] = 1'b1;
        bus.req_dest[3*i +: 3] = d;
        bus.req_data[16*i +: 16] = v;
    endtask

    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] pat [8] = '{3'b011, 3'b110, 3'b101, 3'b111, 3'b010, 3'b000, 3'b100, 3'b111};

    initial begin
        rst = 1'b1; rsv_en = 1'b0; rsv_dest = 3'd0; chk1 = 3'd0; chk2 = 3'd3;
        bus.req = 3'b110; bus.req_dest = 9'd0; bus.req_data = 48'd0;
        @(negedge clk);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_busy", {24'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dest", {29'd0, wdest}, 32'd0);
        chk("rst_data", {16'd0, wdata}, 32'd0);
        chk("rst_gnt", {29'd0, bus.gnt}, 32'b010);
        cyc();
        bus.req = 3'b000;
        cyc();
        rst = 1'b0;
        // all three requesting continuously from reset
        for (int i = 0; i < 3; i++) set_req(i, 3'(i + 1), 16'(16'h1111 * (i + 1)));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_gnt", {29'd0, bus.gnt}, {29'd0, seq[k]});
            chk("rr_wen", {31'd0, wen}, k == 0 ? 32'd0 : 32'd1);
            if (k > 0) begin
                chk("rr_dest", {29'd0, wdest}, 32'((k - 1) % 3 + 1));
                chk("rr_data", {16'd0, wdata}, 32'(16'h1111 * ((k - 1) % 3 + 1)));
            end
            cyc();
        end
        bus.req = 3'b000;
        // reserve 5, then requester 1 writes it
        rsv_en = 1'b1; rsv_dest = 3'd5; chk1 = 3'd5;
        @(negedge clk);
        chk("res_hz_before", {31'd0, hz1}, 32'd0);
        cyc();
        rsv_en = 1'b0;
        set_req(1, 3'd5, 16'hBEEF);
        @(negedge clk);
        chk("res_gnt", {29'd0, bus.gnt}, 32'b010);
        chk("res_busy5", {31'd0, busy[5]}, 32'd1);
        chk("res_hz_gnt", {31'd0, hz1}, 32'd1);
        cyc();
        bus.req = 3'b000;
        @(negedge clk);
        chk("res_wen", {31'd0, wen}, 32'd1);
        chk("res_dest", {29'd0, wdest}, 32'd5);
        chk("res_data", {16'd0, wdata}, 32'h0000BEEF);
        chk("res_hz_wen", {31'd0, hz1}, 32'd1);
        cyc();
        @(negedge clk);
        chk("res_busy5_clr", {31'd0, busy[5]}, 32'd0);
        chk("res_hz_clr", {31'd0, hz1}, 32'd0);
        cyc();
        // write to register 0 is granted but discarded
        set_req(0, 3'd0, 16'h1234);
        @(negedge clk);
        chk("r0_gnt", {29'd0, bus.gnt}, 32'b001);
        cyc();
        bus.req = 3'b000;
        @(negedge clk);
        chk("r0_wen", {31'd0, wen}, 32'd0);
        chk("r0_busy", {24'd0, busy}, 32'd0);
        cyc();
        // reservation of 3 at the edge where its write commits: set wins, no error
        rsv_en = 1'b1; rsv_dest = 3'd3;
        cyc();
        rsv_en = 1'b0;
        set_req(2, 3'd3, 16'h0333);
        @(negedge clk);
        chk("ss_gnt", {29'd0, bus.gnt}, 32'b100);
        cyc();
        bus.req = 3'b000;
        rsv_en = 1'b1; rsv_dest = 3'd3;
        @(negedge clk);
        chk("ss_wen", {31'd0, wen}, 32'd1);
        chk("ss_dest", {29'd0, wdest}, 32'd3);
        cyc();
        rsv_en = 1'b0;
        @(negedge clk);
        chk("ss_busy3", {31'd0, busy[3]}, 32'd1);
        chk("ss_err", {31'd0, err}, 32'd0);
        cyc();
        // double reservation of 2 flags WAW
        rsv_en = 1'b1; rsv_dest = 3'd2;
        cyc();
        @(negedge clk);
        chk("waw_err_first", {31'd0, err}, 32'd0);
        cyc();
        rsv_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("waw_err_hold", {31'd0, err}, 32'd1);
            cyc();
        end
        // mixed request patterns, checked by the model
        for (int k = 0; k < 8; k++) begin
            bus.req = pat[k];
            for (int i = 0; i < 3; i++) begin
                bus.req_dest[3*i +: 3] = 3'((k + i) % 8);
                bus.req_data[16*i +: 16] = 16'(k * 16'h0101 + i);
            end
            rsv_en = k[0]; rsv_dest = 3'(7 - k);
            chk1 = 3'(k); chk2 = 3'(k + 3);
            cyc();
        end
        bus.req = 3'b000; rsv_en = 1'b0;
        cyc();
        // reset mid-write with busy=F0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_err", {31'd0, err}, 32'd0);
        cyc();
        for (int d = 4; d < 8; d++) begin
            rsv_en = 1'b1; rsv_dest = 3'(d);
            cyc();
        end
        rsv_en = 1'b0;
        set_req(1, 3'd1, 16'hAAAA);
        cyc();
        bus.req = 3'b000;
        chk("ar_wen_pre", {31'd0, wen}, 32'd1);
        chk("ar_busy_pre", {24'd0, busy}, 32'hF0);
        #1 rst = 1'b1;
        #1;
        chk("ar_wen", {31'd0, wen}, 32'd0);
        chk("ar_busy", {24'd0, busy}, 32'd0);
        cyc();
        rst = 1'b0;
        set_req(1, 3'd4, 16'h0044);
        set_req(2, 3'd5, 16'h0055);
        @(negedge clk);
        chk("ar_ptr0_gnt", {29'd0, bus.gnt}, 32'b010);
        cyc();
        bus.req = 3'b000;
        @(negedge clk);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, register data width; NREQ is fixed at 3 requesters and 8 registers.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  3  bit i = requester i has a write pending; requester holds req/dest/data stable until granted.
REQ-005 req_dest  in  9  requester i destination in bits [3i+2:3i].
REQ-006 req_data  in  3*DATA_W  requester i data in bits [DATA_W*(i+1)-1:DATA_W*i].
REQ-007 gnt  out  3  one-hot combinational grant; requester i's write is accepted in a cycle where req[i] and gnt[i] are both 1.
REQ-008 reg_write_en  out  1  registered write enable to the register file.
REQ-009 reg_write_dest  out  3  registered write address.
REQ-010 reg_write_data  out  DATA_W  registered write data.
REQ-011 rsv_en  in  1  issue stage reserves a destination (marks it pending).
REQ-012 rsv_dest  in  3  register being reserved.
REQ-013 chk_addr_1, chk_addr_2  in  3 each  read addresses to check for hazards.
REQ-014 hazard_1, hazard_2  out  1 each  combinational: the checked register has a pending write.
REQ-015 busy  out  8  scoreboard bitmap; bit 0 is always 0.
REQ-016 err_waw  out  1  sticky flag: a reservation was made to an already busy register.

Function
REQ-017 Arbitration is round-robin over a 2-bit pointer ptr in {0,1,2}; the search order is ptr, ptr+1, ptr+2 (mod 3); gnt selects the first requester in that order with req set.
REQ-018 gnt is 3'b000 when req is 3'b000; gnt never has more than one bit set.
REQ-019 After a grant to requester i, ptr <= (i+1) mod 3; ptr holds its value in cycles with no grant.
REQ-020 Latency: grant in cycle t puts reg_write_en=1 and the granted dest/data on the outputs in cycle t+1, so the register file writes at the end of t+1.
REQ-021 In a cycle with no grant, reg_write_en <= 0, and reg_write_dest/reg_write_data hold their previous values.
REQ-022 A granted write to dest 0 is accepted (gnt asserted) but reg_write_en <= 0 in the following cycle; the write is discarded.
REQ-023 Scoreboard set: rsv_en=1 with rsv_dest!=0 sets busy[rsv_dest] at the edge; rsv_dest=0 is ignored.
REQ-024 Scoreboard clear: busy[reg_write_dest] clears at the edge that ends a cycle with reg_write_en=1, which is the same edge at which the register file commits the data.
REQ-025 Simultaneous set and clear of the same register at one edge: set wins, and busy stays 1.
REQ-026 hazard_k = busy[chk_addr_k]; chk_addr_k=0 always gives 0; there is no bypass, so hazard stays 1 through the cycle in which reg_write_en drives that register.
REQ-027 rsv_en=1 for a register with busy=1 (and no same-edge clear) sets err_waw=1; err_waw stays 1 until reset.
REQ-028 All sequential elements use rst asynchronously; no other clear mechanism exists.

Reset
REQ-029 While rst=1: ptr=0, busy=8'h00, err_waw=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0; gnt still follows req combinationally with ptr=0.
REQ-030 Reset asserted mid-operation drops any latched write immediately (reg_write_en=0 asynchronously); requesters not yet granted must re-present after reset.

Verification
REQ-031 req=3'b111 held for 6 cycles from reset -> gnt sequence 001,010,100,001,010,100; reg_write_en=1 from the second cycle onward, with each requester's dest/data.
REQ-032 rsv_en with rsv_dest=5, then requester 1 writes dest 5, data 16'hBEEF -> busy[5]=1, hazard=1 for chk_addr 5 through the reg_write_en cycle, busy[5]=0 on the next cycle.
REQ-033 Requester 0 granted with dest 0 -> gnt[0]=1, next cycle reg_write_en=0, busy unchanged.
REQ-034 rsv_dest=3 reserved at the same edge that ends a reg_write_en cycle for dest 3 -> busy[3] stays 1, err_waw stays 0.
REQ-035 Reserve dest 2 twice without an intervening write -> err_waw=1 after the second edge and held until rst.
REQ-036 rst pulsed while reg_write_en=1 and busy=8'hF0 -> reg_write_en=0 and busy=0 immediately; ptr=0 on release.
